// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter that multiplexes NDEV emulated SD requesters onto one IO controller port.
// A requester is blocked after its transfer completes until it drops its request level.
module sd_req_arbiter #(
  parameter int NDEV = 4,
  parameter int IW   = 3
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [32*NDEV-1:0]   req_lba,
  input  logic [NDEV-1:0]      req_rd,
  input  logic [NDEV-1:0]      req_wr,
  output logic [NDEV-1:0]      req_ack,
  output logic [NDEV-1:0]      req_buff_wr,
  input  logic [8*NDEV-1:0]    req_buff_din,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  output logic [IW-1:0]        sd_dev,
  input  logic                 sd_ack,
  input  logic                 sd_buff_wr,
  output logic [7:0]           sd_buff_din
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   rr_ptr;
  logic [NDEV-1:0] hold, hold_nxt;
  logic [NDEV-1:0] eligible;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [31:0]     pick_lba;
  logic            pick_rd, pick_wr;
  int              best_dist;
  logic [NDEV-1:0] gnt_onehot;
  logic [7:0]      gnt_din;
  logic            done;

  // Distance from the round-robin pointer to idx, walking upward and wrapping at NDEV.
  function automatic int ring_dist(input int idx, input logic [IW-1:0] base);
    int d;
    d = idx - int'(base);
    if (d < 0) d = d + NDEV;
    return d;
  endfunction

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    int n;
    n = int'(idx) + 1;
    if (n >= NDEV) n = 0;
    return IW'(n);
  endfunction

  always_comb begin
    eligible  = (req_rd | req_wr) & ~hold;
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_lba  = '0;
    pick_rd   = 1'b0;
    pick_wr   = 1'b0;
    best_dist = NDEV;
    for (int i = 0; i < NDEV; i++) begin
      if (eligible[i] && (ring_dist(i, rr_ptr) < best_dist)) begin
        best_dist = ring_dist(i, rr_ptr);
        pick_vld  = 1'b1;
        pick_idx  = IW'(i);
        pick_lba  = req_lba[32*i +: 32];
        pick_rd   = req_rd[i];
        pick_wr   = req_wr[i];
      end
    end
  end

  always_comb begin
    gnt_onehot = '0;
    gnt_din    = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (gnt == IW'(i)) begin
        gnt_onehot[i] = 1'b1;
        gnt_din       = req_buff_din[8*i +: 8];
      end
    end
  end

  assign done = (state == XFER) && !sd_ack;

  // Set on completion wins over the level-based clear; the clear lands one cycle later if the level is already low.
  always_comb begin
    hold_nxt = hold & (req_rd | req_wr);
    if (done) hold_nxt = hold_nxt | gnt_onehot;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ack     = '0;
    req_buff_wr = '0;
    sd_buff_din = '0;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ISSUE;
      ISSUE: begin
        sd_buff_din = gnt_din;
        if (sd_ack) state_nxt = XFER;
      end
      XFER: begin
        sd_buff_din = gnt_din;
        req_ack     = gnt_onehot & {NDEV{sd_ack}};
        req_buff_wr = gnt_onehot & {NDEV{sd_buff_wr}};
        if (!sd_ack) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!reset_n) begin
      req_ack     = '0;
      req_buff_wr = '0;
      sd_buff_din = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      gnt    <= '0;
      rr_ptr <= '0;
      hold   <= '0;
      sd_rd  <= 1'b0;
      sd_wr  <= 1'b0;
      sd_lba <= '0;
      sd_dev <= '0;
    end else begin
      hold <= hold_nxt;
      if ((state == IDLE) && pick_vld) begin
        gnt    <= pick_idx;
        sd_dev <= pick_idx;
        sd_lba <= pick_lba;
        sd_rd  <= pick_rd;
        sd_wr  <= pick_wr & ~pick_rd;
      end
      if ((state == ISSUE) && sd_ack) begin
        sd_rd <= 1'b0;
        sd_wr <= 1'b0;
      end
      if (done) rr_ptr <= wrap_inc(gnt);
    end
  end

endmodule

// File: doc/sd_req_arbiter.md
SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 SHALL have parameter NDEV, default 4, giving the number of emulated SD requesters (legal 2..8).
REQ-002 SHALL have parameter IW, default 3, giving the index width (IW >= clog2(NDEV)).
REQ-003 SHALL have one clock and a synchronous, active-low reset, named as below.
REQ-004 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-005 reset_n  in  1  synchronous reset, active low.
REQ-006 req_lba  in  32*NDEV  per-requester sector LBA; slice i = [32*i+31:32*i].
REQ-007 req_rd  in  NDEV  per-requester read request level.
REQ-008 req_wr  in  NDEV  per-requester write request level.
REQ-009 req_ack  out  NDEV  per-requester sd_ack (one-hot or zero).
REQ-010 req_buff_wr  out  NDEV  per-requester buffer write strobe.
REQ-011 req_buff_din  in  8*NDEV  per-requester buffer readback data.
REQ-012 sd_lba  out  32  LBA to IO controller.
REQ-013 sd_rd / sd_wr  out  1 each  request to IO controller.
REQ-014 sd_dev  out  IW  index of the granted requester.
REQ-015 sd_ack  in  1  IO controller transfer acknowledge.
REQ-016 sd_buff_wr  in  1  IO controller buffer write strobe.
REQ-017 sd_buff_din  out  8  readback data from the granted requester.

Function
REQ-018 SHALL implement the states IDLE, ISSUE, XFER and RELEASE.
REQ-019 IDLE: eligible = (req_rd|req_wr) & ~hold; if nonzero, SHALL pick the first eligible index at or after rr_ptr (wrapping NDEV-1 -> 0), latch it as gnt, and go to ISSUE on the next edge.
REQ-020 Selection cycle: SHALL register sd_lba = req_lba[gnt], sd_dev = gnt, sd_rd = req_rd[gnt], sd_wr = req_wr[gnt] & ~req_rd[gnt] (read wins when both are set); outputs are valid one cycle after request detection.
REQ-021 ISSUE: SHALL hold sd_rd/sd_wr/sd_lba/sd_dev stable; on sd_ack=1, SHALL clear sd_rd and sd_wr the same edge and go to XFER.
REQ-022 XFER: req_ack[gnt] = sd_ack and req_buff_wr[gnt] = sd_buff_wr, combinational; all other bits SHALL be 0 in every state.
REQ-023 sd_buff_din SHALL equal req_buff_din[gnt] in ISSUE and XFER, and 0 otherwise.
REQ-024 XFER: on sd_ack=0, SHALL set hold[gnt]=1, set rr_ptr = gnt+1 (mod NDEV), and go to RELEASE.
REQ-025 RELEASE: one cycle, no outputs asserted; SHALL then go to IDLE.
REQ-026 hold[i] SHALL clear on any cycle where req_rd[i]=0 and req_wr[i]=0, so a stale level after ack-fall is never re-issued.
REQ-027 In ISSUE and XFER, changes of req_lba, req_rd or req_wr (granted or not) SHALL NOT alter the latched outputs or gnt.
REQ-028 A requester dropping its request during ISSUE SHALL NOT abort the transaction; completion follows sd_ack.
REQ-029 sd_ack=1 observed in IDLE or RELEASE SHALL be ignored (no req_ack bit driven).
REQ-030 rr_ptr arithmetic SHALL wrap modulo NDEV, including non-power-of-2 NDEV.

Reset
REQ-031 While reset_n=0 at a clock edge: state=IDLE, gnt=0, rr_ptr=0, hold=0, sd_rd=0, sd_wr=0, sd_lba=0, sd_dev=0.
REQ-032 While reset_n=0, req_ack, req_buff_wr and sd_buff_din SHALL be 0.
REQ-033 Reset mid-transaction SHALL abandon the grant; after release, a still-asserted request SHALL be re-arbitrated from rr_ptr=0.

Verification
REQ-034 Single read: req_rd[2]=1, req_lba[2]=0x1234 -> next cycle sd_rd=1, sd_lba=0x1234, sd_dev=2; sd_ack pulse -> req_ack=4'b0100, sd_rd clears on the ack-rise edge.
REQ-035 Round robin: req_rd=4'b1011 held, with every request dropped after its own ack falls -> grant order 0,1,3; then with rr_ptr=0 and bit 0 re-raised -> device 0 next.
REQ-036 Stale level: device 1 keeps req_rd=1 for 10 cycles after ack-fall -> no second sd_rd; after it drops and re-raises -> new grant.
REQ-037 Both rd and wr set on device 0 -> sd_rd=1, sd_wr=0.
REQ-038 Routing: during a device-3 transfer, 512 sd_buff_wr strobes -> only req_buff_wr[3] pulses; sd_buff_din tracks req_buff_din[3].
REQ-039 Reset: reset_n=0 asserted in XFER -> all outputs 0 next edge; req_rd[1] still high after release -> reissued with sd_dev=1.
